// File: rtl/avionics_pkg.sv
// Shared definitions for the avionics board: arbiter state encoding,
// default timeout and a small index helper used by the round-robin picker.
package avionics_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_GRANT  = 3'd1,
        ARB_SEND   = 3'd2,
        ARB_SETTLE = 3'd3,
        ARB_DRAIN  = 3'd4
    } arb_state_t;

    // Default number of clock cycles an owner may sit in GRANT without
    // presenting a byte before its grant is taken away.
    localparam int DEFAULT_TIMEOUT = 50000;

    // (base + offset) mod n, assuming base < n and offset < n.
    function automatic int wrap_add(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: starting at ptr and wrapping, returns
// the first asserted request as a one-hot vector plus its index.
module rr_pick
    import avionics_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any
);

    // Walk the request vector from the pointer upward and keep the first hit.
    always_comb begin
        int idx;
        idx        = 0;
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = wrap_add(int'(ptr), i, NUM_REQ);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                winner_idx  = PTR_W'(idx);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one AVR serial transmit path
// (tx_data / new_tx_data / tx_busy) among NUM_REQ requesters.
module uart_tx_arbiter
    import avionics_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int CNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [NUM_REQ-1:0]   last,
    input  logic [8*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 timeout_err,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(TIMEOUT - 1);

    arb_state_t           state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     next_ptr;
    logic [CNT_BITS-1:0]  cnt;
    logic                 last_lat;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // Pointer value used on release: the requester after the current owner.
    assign next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Arbiter FSM with all outputs registered. Strobes default low each cycle.
    // The timeout only advances while the owner has no byte valid, so a long
    // transmitter-busy stall never costs an owner its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            ack         <= '0;
            new_tx_data <= 1'b0;
            timeout_err <= 1'b0;
            tx_data     <= 8'h00;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            last_lat    <= 1'b0;
        end else begin
            ack         <= '0;
            new_tx_data <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (en && pick_any) begin
                        gnt   <= pick_onehot;
                        owner <= pick_idx;
                        cnt   <= '0;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!req[owner] || !en) begin
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= ARB_IDLE;
                    end else if (valid[owner] && !tx_busy) begin
                        tx_data     <= data[owner*8 +: 8];
                        last_lat    <= last[owner];
                        new_tx_data <= 1'b1;
                        ack[owner]  <= 1'b1;
                        state       <= ARB_SEND;
                    end else if (!valid[owner]) begin
                        if (cnt == TIMEOUT_LAST) begin
                            timeout_err <= 1'b1;
                            gnt         <= '0;
                            ptr         <= next_ptr;
                            state       <= ARB_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ARB_SEND: begin
                    cnt   <= '0;
                    state <= ARB_SETTLE;
                end
                ARB_SETTLE: begin
                    state <= ARB_DRAIN;
                end
                ARB_DRAIN: begin
                    if (!tx_busy) begin
                        if (last_lat || !en || !req[owner]) begin
                            gnt   <= '0;
                            ptr   <= next_ptr;
                            state <= ARB_IDLE;
                        end else begin
                            state <= ARB_GRANT;
                        end
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte scoreboard, a requester
// model that advances on ack, and a simple busy model of the AVR transmitter.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 20;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   valid;
    logic [NUM_REQ-1:0]   last;
    logic [8*NUM_REQ-1:0] data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ack;
    logic                 timeout_err;
    logic [7:0]           tx_data;
    logic                 new_tx_data;
    logic                 tx_busy;

    typedef struct {
        int         who;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];

    logic [NUM_REQ-1:0] req_on;
    logic [NUM_REQ-1:0] valid_en;
    logic [7:0]         mem [NUM_REQ][64];
    int                 pkt_pos [NUM_REQ] = '{default: 0};
    int                 pkt_end [NUM_REQ] = '{default: 0};
    int                 busy_len;
    int                 busy_cnt = 0;
    logic               force_busy;

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TIMEOUT  (TMO),
        .CNT_BITS (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .valid       (valid),
        .last        (last),
        .data        (data),
        .gnt         (gnt),
        .ack         (ack),
        .timeout_err (timeout_err),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    // Requester outputs derived from each requester's packet buffer.
    always_comb begin
        req   = '0;
        valid = '0;
        last  = '0;
        data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]          = req_on[i] && (pkt_pos[i] < pkt_end[i]);
            valid[i]        = req[i] && valid_en[i];
            last[i]         = (pkt_pos[i] == pkt_end[i] - 1);
            data[8*i +: 8]  = mem[i][pkt_pos[i] & 63];
        end
    end

    // Each ack moves that requester on to its next byte.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (ack[i]) pkt_pos[i] <= pkt_pos[i] + 1;
    end

    // AVR transmitter: busy for busy_len cycles starting the cycle after a strobe.
    always @(posedge clk) begin
        if (new_tx_data) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Load a packet into requester who; the first npush bytes go to the scoreboard.
    task automatic applyStimulus(input int who, input int len, input logic [7:0] first,
                                 input int npush);
        for (int k = 0; k < len; k++)
            mem[who][(pkt_pos[who] + k) & 63] = first + 8'(k);
        pkt_end[who] = pkt_pos[who] + len;
        for (int k = 0; k < npush; k++)
            sb.push_back('{who: who, b: first + 8'(k)});
    endtask

    task automatic waitIdle(input int budget, input string tag, output int seen);
        int n;
        n    = 0;
        seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (new_tx_data) seen++;
        end while ((sb.size() != 0 || gnt != 0) && n < budget);
        checkOutput({tag, "_finished"}, 32'(n < budget), 32'd1);
    endtask

    // Scoreboard monitor: every strobe pops one expected byte and owner.
    always @(negedge clk) begin
        if (rst_n) begin
            if (new_tx_data) begin
                checkOutput("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("tx_data", 32'(tx_data), 32'(e.b));
                    checkOutput("ack_with_strobe", 32'(ack), 32'(oh(e.who)));
                    checkOutput("gnt_at_strobe", 32'(gnt), 32'(oh(e.who)));
                end
            end else begin
                checkOutput("ack_without_strobe", 32'(ack), 32'd0);
            end
            checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (timeout_err) timeouts++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        int k;
        int seen;

        rst_n      = 1'b0;
        en         = 1'b0;
        req_on     = '0;
        valid_en   = '1;
        force_busy = 1'b0;
        busy_len   = 10;

        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_new_tx", 32'(new_tx_data), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        $display("[TB] all four requesters at once, pointer from reset");
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1, 8'hB0 + 8'(i), 1);
        req_on = 4'b1111;
        waitIdle(400, "all_req", seen);
        checkOutput("all_req_count", 32'(seen), 32'd4);
        req_on = '0;

        $display("[TB] pointer back at 0: requesters 1 and 3 together");
        applyStimulus(1, 1, 8'hC1, 1);
        applyStimulus(3, 1, 8'hC3, 1);
        req_on = 4'b1010;
        waitIdle(200, "ptr_wrap", seen);
        checkOutput("ptr_wrap_count", 32'(seen), 32'd2);
        req_on = '0;

        $display("[TB] requester 0 three byte packet with busy stalls");
        applyStimulus(0, 3, 8'hA1, 3);
        req_on[0] = 1'b1;
        waitIdle(300, "three_byte", seen);
        checkOutput("three_byte_count", 32'(seen), 32'd3);
        req_on = '0;

        $display("[TB] requester 2 never valid, requester 3 waiting");
        valid_en[2] = 1'b0;
        applyStimulus(2, 1, 8'hD2, 0);
        applyStimulus(3, 1, 8'hD3, 1);
        req_on = 4'b1100;
        n = 0;
        while (!gnt[2] && n < 50) begin @(negedge clk); n++; end
        checkOutput("tmo_gnt2", 32'(gnt), 32'b0100);
        n = 0;
        while (!timeout_err && n < 100) begin @(negedge clk); n++; end
        checkOutput("tmo_delay", 32'(n), 32'(TMO));
        checkOutput("tmo_gnt_clear", 32'(gnt), 32'd0);
        req_on[2]   = 1'b0;
        valid_en[2] = 1'b1;
        @(negedge clk);
        checkOutput("tmo_single_pulse", 32'(timeout_err), 32'd0);
        waitIdle(200, "tmo_next", seen);
        checkOutput("tmo_next_count", 32'(seen), 32'd1);
        req_on = '0;

        $display("[TB] transmitter busy for 100 cycles while owner valid");
        force_busy = 1'b1;
        applyStimulus(0, 1, 8'hE0, 1);
        req_on[0] = 1'b1;
        k = 0;
        repeat (100) begin @(negedge clk); if (new_tx_data) k++; end
        checkOutput("busy_no_strobe", 32'(k), 32'd0);
        checkOutput("busy_still_owner", 32'(gnt), 32'b0001);
        force_busy = 1'b0;
        waitIdle(100, "busy_release", seen);
        checkOutput("busy_sent_once", 32'(seen), 32'd1);
        req_on = '0;

        $display("[TB] en dropped during drain of byte 2 of 5");
        applyStimulus(1, 5, 8'h50, 2);
        req_on[1] = 1'b1;
        k = 0;
        n = 0;
        while (k < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (new_tx_data) k++;
        end
        checkOutput("en_two_bytes", 32'(k), 32'd2);
        repeat (2) @(negedge clk);
        en = 1'b0;
        k  = 0;
        repeat (60) begin @(negedge clk); if (new_tx_data) k++; end
        checkOutput("en_off_no_strobe", 32'(k), 32'd0);
        checkOutput("en_off_gnt", 32'(gnt), 32'd0);
        for (int i = 2; i < 5; i++) sb.push_back('{who: 1, b: 8'h50 + 8'(i)});
        en = 1'b1;
        waitIdle(300, "en_resume", seen);
        checkOutput("en_resume_count", 32'(seen), 32'd3);
        req_on = '0;

        $display("[TB] reset during settle");
        applyStimulus(2, 3, 8'h60, 1);
        req_on[2] = 1'b1;
        n = 0;
        while (!new_tx_data && n < 50) begin @(negedge clk); n++; end
        checkOutput("rst_mid_strobe_seen", 32'(new_tx_data), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_new_tx", 32'(new_tx_data), 32'd0);
        checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mid_ack", 32'(ack), 32'd0);
        checkOutput("rst_mid_tx_data", 32'(tx_data), 32'd0);
        req_on[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 2, 8'h70, 2);
        req_on[1] = 1'b1;
        n = 0;
        while (gnt == 0 && n < 50) begin @(negedge clk); n++; end
        checkOutput("post_rst_gnt", 32'(gnt), 32'b0010);
        waitIdle(200, "post_rst", seen);
        checkOutput("post_rst_count", 32'(seen), 32'd2);
        req_on = '0;

        repeat (3) @(negedge clk);
        checkOutput("timeout_total", 32'(timeouts), 32'd1);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
